// File: rtl/pe_array_stream.sv
// Streaming PE array: MAC_NUM lanes accumulate act[i]*wet over a framed dot product, then requantize.
// Latency: last beat accepted in cycle t -> out_valid from cycle t+2 when the output buffer is free.
// Backpressure: in_ready drops while a finished vector waits in RQ; out_data holds while out_valid & ~out_ready.
module pe_array_stream #(
  parameter int MAC_NUM = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32,
  parameter int BW_OUT  = 8,
  parameter int SHIFT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      soft_clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic signed [BW_ACT-1:0]  in_act [MAC_NUM],
  input  logic signed [BW_WET-1:0]  in_wet,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_round,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BW_OUT-1:0]  out_data [MAC_NUM],
  output logic [MAC_NUM-1:0]        out_sat,
  output logic                      busy
);

  localparam int BW_PROD = BW_ACT + BW_WET;
  localparam int BW_RQ   = BW_ACCU + 1;

  // Output range limits, sign-extended into the requantize width for comparison.
  localparam logic signed [BW_OUT-1:0] O_MAX = {1'b0, {(BW_OUT-1){1'b1}}};
  localparam logic signed [BW_OUT-1:0] O_MIN = {1'b1, {(BW_OUT-1){1'b0}}};
  localparam logic signed [BW_RQ-1:0]  Q_MAX = BW_RQ'(O_MAX);
  localparam logic signed [BW_RQ-1:0]  Q_MIN = BW_RQ'(O_MIN);
  localparam logic [31:0]              ACCU_W = 32'(BW_ACCU);

  typedef enum logic {ST_ACC, ST_RQ} state_e;

  state_e                     state_q, state_d;
  logic                       first_q, first_d;
  logic signed [BW_ACCU-1:0]  acc_q [MAC_NUM];
  logic signed [BW_ACCU-1:0]  acc_d [MAC_NUM];
  logic [SHIFT_W-1:0]         shift_q, shift_d;
  logic                       round_q, round_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [BW_OUT-1:0]   out_data_q [MAC_NUM];
  logic signed [BW_OUT-1:0]   out_data_d [MAC_NUM];
  logic [MAC_NUM-1:0]         out_sat_q, out_sat_d;

  logic signed [BW_ACCU-1:0]  prod_ext [MAC_NUM];
  logic signed [BW_OUT-1:0]   rq_data [MAC_NUM];
  logic [MAC_NUM-1:0]         rq_sat;
  logic                       accept;
  logic                       buf_free;

  assign in_ready  = (state_q == ST_ACC);
  assign accept    = in_valid & in_ready;
  assign buf_free  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = ~first_q | (state_q == ST_RQ) | out_valid_q;

  // Full signed product of each lane's activation with the broadcast weight, sign-extended to accumulator width.
  always_comb begin
    for (int i = 0; i < MAC_NUM; i++) begin
      prod_ext[i] = BW_ACCU'(BW_PROD'(in_act[i]) * BW_PROD'(in_wet));
    end
  end

  // Requantize each frozen accumulator: optional half-up bias, arithmetic shift, clamp to the output range.
  always_comb begin
    logic signed [BW_RQ-1:0] bias;
    logic signed [BW_RQ-1:0] r;
    logic signed [BW_RQ-1:0] q;
    bias   = '0;
    r      = '0;
    q      = '0;
    rq_sat = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      rq_data[i] = '0;
      bias = '0;
      if (round_q && (shift_q != '0)) begin
        bias = BW_RQ'(1) << (shift_q - SHIFT_W'(1));
      end
      r = BW_RQ'(acc_q[i]) + bias;
      // Shifting the whole accumulator out leaves only its sign; rounding cannot reach that far.
      if (32'(shift_q) >= ACCU_W) begin
        q = acc_q[i][BW_ACCU-1] ? '1 : '0;
      end else begin
        q = r >>> shift_q;
      end
      if (q > Q_MAX) begin
        rq_data[i] = O_MAX;
        rq_sat[i]  = 1'b1;
      end else if (q < Q_MIN) begin
        rq_data[i] = O_MIN;
        rq_sat[i]  = 1'b1;
      end else begin
        rq_data[i] = q[BW_OUT-1:0];
      end
    end
  end

  // Next-state: accumulate in ACC, hand the result to the output buffer in RQ; soft_clear overrides all.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (soft_clear) begin
      state_d     = ST_ACC;
      first_d     = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      // Pop first; a same-cycle reload below re-asserts valid with the new result.
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            for (int i = 0; i < MAC_NUM; i++) begin
              acc_d[i] = (first_q ? '0 : acc_q[i]) + prod_ext[i];
            end
            first_d = in_last;
            if (in_last) begin
              shift_d = cfg_shift;
              round_d = cfg_round;
              state_d = ST_RQ;
            end
          end
        end
        ST_RQ: begin
          if (buf_free) begin
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            out_valid_d = 1'b1;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACC;
      first_q     <= 1'b1;
      shift_q     <= '0;
      round_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= '0;
      for (int i = 0; i < MAC_NUM; i++) begin
        acc_q[i]      <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      shift_q     <= shift_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      for (int i = 0; i < MAC_NUM; i++) begin
        acc_q[i]      <= acc_d[i];
        out_data_q[i] <= out_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pe_array_stream.sv
// Bench for pe_array_stream: directed table, multi-cycle corner sequences, randomized vs a reference model.
module tb_pe_array_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              reset_n;
  logic              soft_clear;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic signed [7:0] in_act [4];
  logic signed [7:0] in_wet;
  logic [7:0]        cfg_shift;
  logic              cfg_round;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data [4];
  logic [3:0]        out_sat;
  logic              busy;

  pe_array_stream dut (
    .clk(clk), .reset_n(reset_n), .soft_clear(soft_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_act(in_act), .in_wet(in_wet), .cfg_shift(cfg_shift), .cfg_round(cfg_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Current vector being driven: beat count, weights, activations [beat][lane], requant config.
  int b_n;
  int b_sh;
  bit b_rnd;
  int b_wet [16];
  int b_act [16][4];
  int t_last;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sat;
  } res_t;
  res_t exp_q [$];

  typedef struct {
    int          n;
    int          wet [4];
    int          act [4][4];
    int          sh;
    bit          rnd;
    logic [31:0] edata;
    logic [3:0]  esat;
  } vec_t;
  vec_t tv [8];

  function automatic logic [31:0] pack_out();
    logic [31:0] p;
    for (int l = 0; l < 4; l++) p[l*8 +: 8] = out_data[l];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: exact integer dot product, 32-bit wrap, then the requantize rules as plain arithmetic.
  function automatic res_t model();
    res_t e;
    e.data = '0;
    e.sat  = '0;
    for (int l = 0; l < 4; l++) begin
      longint s = 0;
      int     a;
      longint q;
      longint r;
      for (int k = 0; k < b_n; k++) s += longint'(b_wet[k]) * longint'(b_act[k][l]);
      a = int'(s);
      if (b_sh >= 32) begin
        q = (a < 0) ? -1 : 0;
      end else begin
        r = longint'(a) + ((b_rnd && b_sh > 0) ? (longint'(1) << (b_sh - 1)) : 0);
        q = r >>> b_sh;
      end
      if (q > 127) begin q = 127; e.sat[l] = 1'b1; end
      else if (q < -128) begin q = -128; e.sat[l] = 1'b1; end
      e.data[l*8 +: 8] = q[7:0];
    end
    return e;
  endfunction

  task automatic load_tv(input int i);
    b_n = tv[i].n; b_sh = tv[i].sh; b_rnd = tv[i].rnd;
    for (int k = 0; k < 4; k++) begin
      b_wet[k] = tv[i].wet[k];
      for (int l = 0; l < 4; l++) b_act[k][l] = tv[i].act[k][l];
    end
  endtask

  // Drive the current vector beat by beat; optional random idle gaps. Records the last-beat cycle.
  task automatic drive_vec(input bit gaps);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < b_n && guard < 300) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_wet    = 8'(b_wet[idx]);
        for (int l = 0; l < 4; l++) in_act[l] = 8'(b_act[idx][l]);
        in_last   = (idx == b_n - 1);
        cfg_shift = 8'(b_sh);
        cfg_round = b_rnd;
      end
      #1;
      acc = in_valid && in_ready;
      if (acc && idx == b_n - 1) t_last = cyc;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idx < b_n) check("drive_timeout", 64'(idx), 64'(b_n));
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] held;
    int          bad;
    int          got;
    int          guard;
    res_t        e;
    localparam int NRAND = 40;

    // Directed vectors: expected results worked out by hand.
    tv[0].n = 3; tv[0].wet = '{2, 3, -1, 0}; tv[0].sh = 0; tv[0].rnd = 0;
    tv[0].act[0] = '{10, 1, -10, 0}; tv[0].act[1] = '{20, 1, 0, 0};
    tv[0].act[2] = '{5, 1, 0, 100};  tv[0].act[3] = '{0, 0, 0, 0};
    tv[0].edata = 32'h9CEC044B; tv[0].esat = 4'b0000;
    tv[1].n = 1; tv[1].wet = '{127, 0, 0, 0}; tv[1].sh = 0; tv[1].rnd = 0;
    tv[1].act[0] = '{127, -128, 1, 0};
    tv[1].edata = 32'h007F807F; tv[1].esat = 4'b0011;
    for (int i = 2; i < 6; i++) begin
      tv[i].n = 1; tv[i].wet = '{1, 0, 0, 0}; tv[i].act[0] = '{5, -5, 7, -7};
    end
    tv[2].sh = 1;  tv[2].rnd = 1; tv[2].edata = 32'hFD04FE03; tv[2].esat = 4'b0000;
    tv[3].sh = 1;  tv[3].rnd = 0; tv[3].edata = 32'hFC03FD02; tv[3].esat = 4'b0000;
    tv[4].sh = 40; tv[4].rnd = 1; tv[4].edata = 32'hFF00FF00; tv[4].esat = 4'b0000;
    tv[5].sh = 40; tv[5].rnd = 0; tv[5].edata = 32'hFF00FF00; tv[5].esat = 4'b0000;
    tv[6].n = 2; tv[6].wet = '{100, -50, 0, 0}; tv[6].sh = 4; tv[6].rnd = 1;
    tv[6].act[0] = '{100, -100, 3, -3}; tv[6].act[1] = '{10, 0, 2, -2};
    tv[6].edata = 32'hF40D807F; tv[6].esat = 4'b0011;
    tv[7].n = 1; tv[7].wet = '{-1, 0, 0, 0}; tv[7].sh = 32; tv[7].rnd = 0;
    tv[7].act[0] = '{1, -1, 0, 127};
    tv[7].edata = 32'hFF0000FF; tv[7].esat = 4'b0000;

    reset_n = 1'b0; soft_clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_wet = '0; cfg_shift = '0; cfg_round = 1'b0; out_ready = 1'b0;
    for (int l = 0; l < 4; l++) in_act[l] = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {out_valid, busy, in_ready, out_sat, pack_out()}, {1'b0, 1'b0, 1'b1, 4'b0, 32'b0});
    reset_n = 1'b1;

    // Table: latency, data, saturation flags, then the buffer empties with ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_tv(i);
      drive_vec(1'b0);
      wait_valid(seen);
      check("latency", seen ? 64'(cyc - t_last) : 64'd999, 64'd2);
      check("data", pack_out(), tv[i].edata);
      check("sat", out_sat, tv[i].esat);
      @(negedge clk);
      check("pop_idle", {out_valid, busy}, 2'b00);
    end

    // Back-pressure: second vector stalls in RQ while the first result is held.
    out_ready = 1'b0;
    load_tv(2); drive_vec(1'b0); wait_valid(seen);
    check("bp_first_valid", seen, 1'b1);
    held = pack_out();
    load_tv(0); drive_vec(1'b0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || pack_out() !== held || busy !== 1'b1) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_held_data", held, tv[2].edata);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", {out_valid, pack_out()}, {1'b1, tv[0].edata});
    @(negedge clk);
    check("bp_drain", out_valid, 1'b0);

    // soft_clear mid-vector: the partial sum must not leak into the next vector.
    @(negedge clk);
    in_valid = 1'b1; in_last = 1'b0; in_wet = 8'sd100;
    for (int l = 0; l < 4; l++) in_act[l] = 8'sd50;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("clr_busy_before", busy, 1'b1);
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    check("clr_busy_after", busy, 1'b0);
    load_tv(0); drive_vec(1'b1); wait_valid(seen);
    check("clr_sum", {seen, pack_out()}, {1'b1, tv[0].edata});
    @(negedge clk);

    // soft_clear while a result is pending: it is dropped and never reappears.
    out_ready = 1'b0;
    load_tv(1); drive_vec(1'b0); wait_valid(seen);
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    check("clr_out", {out_valid, busy}, 2'b00);
    out_ready = 1'b1;
    bad = 0;
    repeat (3) begin @(negedge clk); if (out_valid) bad++; end
    check("clr_no_ghost", 64'(bad), 64'd0);

    // Asynchronous reset while a second vector waits in RQ.
    out_ready = 1'b0;
    load_tv(0); drive_vec(1'b0); wait_valid(seen);
    load_tv(1); drive_vec(1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async", {out_valid, busy, in_ready, out_sat, pack_out()}, {1'b0, 1'b0, 1'b1, 4'b0, 32'b0});
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    load_tv(3); drive_vec(1'b0); wait_valid(seen);
    check("rst_fresh", {seen, pack_out()}, {1'b1, tv[3].edata});
    @(negedge clk);

    // Randomized traffic with idle gaps and random consumer stalls.
    got = 0;
    guard = 0;
    fork
      begin
        for (int v = 0; v < NRAND; v++) begin
          b_n = $urandom_range(1, 6);
          for (int k = 0; k < b_n; k++) begin
            b_wet[k] = int'($urandom_range(0, 255)) - 128;
            for (int l = 0; l < 4; l++) b_act[k][l] = int'($urandom_range(0, 255)) - 128;
          end
          b_sh  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 12)) : int'($urandom_range(28, 255));
          b_rnd = 1'($urandom_range(0, 1));
          exp_q.push_back(model());
          drive_vec(1'b1);
        end
      end
      begin
        while (got < NRAND && guard < 20000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_extra", 1'b1, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check("rnd_data", pack_out(), e.data);
              check("rnd_sat", out_sat, e.sat);
            end
            got++;
          end
          guard++;
        end
      end
    join
    check("rnd_count", 64'(got), 64'(NRAND));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
